// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: state encoding and BCD digit limits.
package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_LAP   = 2'd2;
    localparam logic [1:0] ST_PAUSE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_LAP   = ST_LAP,
        S_PAUSE = ST_PAUSE
    } state_t;

    localparam logic [3:0] DIGIT_MAX_ONES = 4'd9;
    localparam logic [3:0] DIGIT_MAX_TENS = 4'd5;
    localparam int         NUM_DIGITS     = 4;

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One BCD digit of the mm:ss time: wraps at MAX and emits a same-cycle carry to the next digit.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] MAX = DIGIT_MAX_ONES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] q,
    output logic       carry
);

    logic [3:0] r_q;

    // >= rather than == so a corrupted value can never sit outside 0..MAX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= 4'd0;
        end else if (clr) begin
            r_q <= 4'd0;
        end else if (inc) begin
            r_q <= (r_q >= MAX) ? 4'd0 : r_q + 4'd1;
        end
    end

    assign q     = r_q;
    assign carry = inc && !clr && (r_q >= MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap stopwatch controller: drives the prescaler and accumulates its ticks as BCD mm:ss.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter logic [31:0] PRESET = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    input  logic        tc,
    output logic        cnt_enable,
    output logic        cnt_load,
    output logic [31:0] cnt_din,
    output logic [15:0] disp,
    output logic        running,
    output logic        paused,
    output logic        wrap
);

    state_t      r_state;
    logic [15:0] r_lap;
    logic        r_load_req;
    logic        r_cnt_load;
    logic        r_cnt_enable;
    logic        r_wrap;

    logic                  w_running;
    logic                  w_tick;
    logic                  w_clr;
    logic [NUM_DIGITS:0]   w_chain;
    logic [15:0]           w_time;

    assign w_running  = (r_state == S_RUN) || (r_state == S_LAP);
    // A tc in the same cycle as a pause request still counts: gating uses the current state.
    assign w_tick     = tc && w_running;
    assign w_clr      = clear && (r_state == S_PAUSE);
    assign w_chain[0] = w_tick;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            bcd_digit #(
                .MAX((gi % 2 == 0) ? DIGIT_MAX_ONES : DIGIT_MAX_TENS)
            ) u_digit (
                .clk   (clk),
                .reset (reset),
                .inc   (w_chain[gi]),
                .clr   (w_clr),
                .q     (w_time[gi*4 +: 4]),
                .carry (w_chain[gi+1])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_lap        <= 16'h0000;
            r_load_req   <= 1'b0;
            r_cnt_load   <= 1'b0;
            r_cnt_enable <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            // Prescaler controls lag the state by one edge.
            r_cnt_enable <= w_running;
            r_cnt_load   <= r_load_req;
            r_load_req   <= 1'b0;
            r_wrap       <= w_chain[NUM_DIGITS];
            case (r_state)
                S_IDLE: begin
                    if (start_stop) begin
                        r_state    <= S_RUN;
                        r_load_req <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (start_stop) begin
                        r_state <= S_PAUSE;
                    end else if (lap) begin
                        r_lap   <= w_time;
                        r_state <= S_LAP;
                    end
                end
                S_LAP: begin
                    if (start_stop) begin
                        r_state <= S_PAUSE;
                    end else if (lap) begin
                        r_state <= S_RUN;
                    end
                end
                S_PAUSE: begin
                    if (clear) begin
                        r_state    <= S_IDLE;
                        r_load_req <= 1'b1;
                    end else if (start_stop) begin
                        r_state <= S_RUN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cnt_enable = r_cnt_enable;
    assign cnt_load   = r_cnt_load;
    assign cnt_din    = PRESET;
    assign wrap       = r_wrap;
    assign running    = w_running;
    assign paused     = (r_state == S_PAUSE);
    assign disp       = (r_state == S_LAP) ? r_lap : w_time;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: vector table, directed corner sequences, random run vs seconds-based model.
module tb_stopwatch_ctrl;

    localparam logic [31:0] TB_PRESET = 32'hCAFE_0123;
    localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_stop = 1'b0, lap = 1'b0, clear = 1'b0, tc = 1'b0;
    logic        cnt_enable, cnt_load, running, paused, wrap;
    logic [31:0] cnt_din;
    logic [15:0] disp;

    int n_checks = 0;
    int n_errors = 0;
    int n_edges  = 0;

    // Reference model: time kept as plain seconds 0..3599.
    int   m_state, m_secs, m_lap_secs;
    logic m_load_pend;
    logic exp_en, exp_load, exp_wrap;

    stopwatch_ctrl #(.PRESET(TB_PRESET)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .tc         (tc),
        .cnt_enable (cnt_enable),
        .cnt_load   (cnt_load),
        .cnt_din    (cnt_din),
        .disp       (disp),
        .running    (running),
        .paused     (paused),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;
    always @(posedge clk) n_edges++;

    typedef struct {
        logic        ss, lp, cl, t;
        logic [15:0] e_disp;
        logic        e_run, e_pau, e_en, e_ld, e_wr;
    } vec_t;
    vec_t vecs[7];

    function automatic logic [15:0] to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE; m_secs = 0; m_lap_secs = 0; m_load_pend = 1'b0;
        exp_en = 1'b0; exp_load = 1'b0; exp_wrap = 1'b0;
    endtask

    task automatic model_step(input logic ss, input logic lp, input logic cl, input logic t);
        logic counting;
        counting = (m_state == M_RUN) || (m_state == M_LAP);
        exp_en = counting;
        exp_load = m_load_pend;
        m_load_pend = 1'b0;
        exp_wrap = 1'b0;
        case (m_state)
            M_IDLE:  if (ss) begin m_state = M_RUN; m_load_pend = 1'b1; end
            M_RUN:   if (ss) m_state = M_PAUSE;
                     else if (lp) begin m_lap_secs = m_secs; m_state = M_LAP; end
            M_LAP:   if (ss) m_state = M_PAUSE; else if (lp) m_state = M_RUN;
            default: if (cl) begin m_secs = 0; m_state = M_IDLE; m_load_pend = 1'b1; end
                     else if (ss) m_state = M_RUN;
        endcase
        if (counting && t) begin
            m_secs = m_secs + 1;
            if (m_secs == 3600) begin m_secs = 0; exp_wrap = 1'b1; end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".disp"}, 32'(disp),
              32'((m_state == M_LAP) ? to_bcd(m_lap_secs) : to_bcd(m_secs)));
        check({tag, ".running"}, 32'(running), 32'((m_state == M_RUN) || (m_state == M_LAP)));
        check({tag, ".paused"}, 32'(paused), 32'(m_state == M_PAUSE));
        check({tag, ".cnt_enable"}, 32'(cnt_enable), 32'(exp_en));
        check({tag, ".cnt_load"}, 32'(cnt_load), 32'(exp_load));
        check({tag, ".wrap"}, 32'(wrap), 32'(exp_wrap));
        check({tag, ".cnt_din"}, cnt_din, TB_PRESET);
    endtask

    task automatic cyc(input logic ss, input logic lp, input logic cl, input logic t);
        @(negedge clk);
        start_stop = ss; lap = lp; clear = cl; tc = t;
        @(posedge clk);
        #1;
        start_stop = 1'b0; lap = 1'b0; clear = 1'b0; tc = 1'b0;
        model_step(ss, lp, cl, t);
        check_model("model");
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int edges_before;
        logic r_ss, r_lp, r_cl, r_t;
        int btn;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0004, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        model_reset();
        #12;
        check("rst.disp", 32'(disp), 32'h0);
        check("rst.running", 32'(running), 32'h0);
        check("rst.paused", 32'(paused), 32'h0);
        check("rst.cnt_enable", 32'(cnt_enable), 32'h0);
        check("rst.cnt_load", 32'(cnt_load), 32'h0);
        check("rst.wrap", 32'(wrap), 32'h0);
        check("rst.cnt_din", cnt_din, TB_PRESET);
        @(negedge clk); reset = 1'b0;

        // IDLE ignores lap and clear.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 7; i++) begin
            cyc(vecs[i].ss, vecs[i].lp, vecs[i].cl, vecs[i].t);
            check($sformatf("vec%0d.disp", i), 32'(disp), 32'(vecs[i].e_disp));
            check($sformatf("vec%0d.running", i), 32'(running), 32'(vecs[i].e_run));
            check($sformatf("vec%0d.paused", i), 32'(paused), 32'(vecs[i].e_pau));
            check($sformatf("vec%0d.cnt_enable", i), 32'(cnt_enable), 32'(vecs[i].e_en));
            check($sformatf("vec%0d.cnt_load", i), 32'(cnt_load), 32'(vecs[i].e_ld));
            check($sformatf("vec%0d.wrap", i), 32'(wrap), 32'(vecs[i].e_wr));
        end

        // Digit carries and the 59:59 rollover.
        ticks(4);
        check("sec_ones_9", 32'(disp), 32'h0009);
        ticks(1);
        check("carry_sec", 32'(disp), 32'h0010);
        ticks(589);
        check("at_0959", 32'(disp), 32'h0959);
        ticks(1);
        check("carry_min", 32'(disp), 32'h1000);
        ticks(2999);
        check("at_5959", 32'(disp), 32'h5959);
        check("wrap_before", 32'(wrap), 32'h0);
        ticks(1);
        check("rollover_disp", 32'(disp), 32'h0000);
        check("wrap_pulse", 32'(wrap), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("wrap_one_cycle", 32'(wrap), 32'h0);

        // Lap freezes the display while time keeps counting.
        ticks(12);
        check("pre_lap", 32'(disp), 32'h0012);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            ticks(1);
            check("lap_frozen", 32'(disp), 32'h0012);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("lap_release", 32'(disp), 32'h0015);

        // Pause holds time, resume issues no load.
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        ticks(7);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("pause.paused", 32'(paused), 32'h1);
        check("pause.disp", 32'(disp), 32'h0007);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("pause.tc_ignored", 32'(disp), 32'h0007);
        check("pause.enable_off", 32'(cnt_enable), 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("resume.running", 32'(running), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("resume.no_load", 32'(cnt_load), 32'h0);
        check("resume.enable", 32'(cnt_enable), 32'h1);

        // Clear ignored in RUN; clear beats start_stop in PAUSE.
        ticks(23);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("run_clear.disp", 32'(disp), 32'h0030);
        check("run_clear.running", 32'(running), 32'h1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        check("clear.disp", 32'(disp), 32'h0000);
        check("clear.idle_running", 32'(running), 32'h0);
        check("clear.idle_paused", 32'(paused), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("clear.load", 32'(cnt_load), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("clear.load_once", 32'(cnt_load), 32'h0);

        // Asynchronous reset mid-RUN at 03:41.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        ticks(221);
        check("pre_async.disp", 32'(disp), 32'h0341);
        @(negedge clk);
        #2;
        edges_before = n_edges;
        reset = 1'b1;
        #1;
        check("async.no_edge", n_edges, edges_before);
        check("async.disp", 32'(disp), 32'h0);
        check("async.running", 32'(running), 32'h0);
        check("async.paused", 32'(paused), 32'h0);
        check("async.cnt_enable", 32'(cnt_enable), 32'h0);
        check("async.cnt_load", 32'(cnt_load), 32'h0);
        check("async.wrap", 32'(wrap), 32'h0);
        model_reset();
        @(negedge clk); reset = 1'b0;

        // Random single-button stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            btn  = $urandom_range(0, 9);
            r_ss = (btn == 0);
            r_lp = (btn == 1);
            r_cl = (btn == 2);
            r_t  = ($urandom_range(0, 1) == 1);
            cyc(r_ss, r_lp, r_cl, r_t);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Controller that sequences the prescaler `counter` (the 32-bit modulo counter with `enable`/`load`/`din`/`tc`) to form a start/stop/lap stopwatch. It accepts one-cycle button pulses and owns the counter's `enable`, `load` and `din`. Each `tc` pulse is one tick, and ticks accumulate into a 4-digit BCD mm:ss value for the display driver. One instance sits between the debounced button logic and the seven-segment mux.

## Interface
- `PRESET`, default 32'd0: value driven on `cnt_din` whenever the prescaler is reloaded. This restarts the tick phase.
- `clk` input 1: system clock, one clock domain.
- `reset` input 1: asynchronous, active-high reset.
- `start_stop` input 1: one-cycle pulse that toggles running/paused.
- `lap` input 1: one-cycle pulse that freezes or unfreezes the display while running.
- `clear` input 1: one-cycle pulse that zeroes the time. It is honoured only in PAUSE.
- `tc` input 1: terminal-count pulse from the prescaler, already qualified by its enable.
- `cnt_enable` output 1: prescaler enable.
- `cnt_load` output 1: prescaler load strobe, one-cycle pulse.
- `cnt_din` output 32: prescaler load value, always equal to `PRESET`.
- `disp` output 16: BCD digits in the order {min_tens, min_ones, sec_tens, sec_ones}.
- `running` output 1: high in RUN or LAP.
- `paused` output 1: high in PAUSE.
- `wrap` output 1: one-cycle pulse when the time rolls over from 59:59 to 00:00.

## Operation
- States: IDLE, RUN, LAP, PAUSE. Reset enters IDLE.
- Input priority within one cycle: `clear` > `start_stop` > `lap`. Only the winning input acts; lower-priority pulses in the same cycle are dropped.
- IDLE:
  - Time is 00:00 and `cnt_enable`=0.
  - `start_stop` moves to RUN and issues one `cnt_load` pulse.
  - `lap` and `clear` are ignored.
- RUN:
  - Each `tc`=1 increments the time by one second.
  - `start_stop` moves to PAUSE.
  - `lap` copies the live time into `lap_reg` and moves to LAP.
  - `clear` is ignored.
- LAP:
  - Time keeps counting; `disp` shows `lap_reg`.
  - `lap` returns to RUN, and `disp` shows live time again.
  - `start_stop` moves to PAUSE, and `disp` shows live time.
  - `clear` is ignored.
- PAUSE:
  - `cnt_enable`=0, so the prescaler holds its phase.
  - `start_stop` returns to RUN with no load, so the tick phase resumes.
  - `clear` zeroes the time, issues a `cnt_load` pulse and moves to IDLE.
  - `lap` is ignored.
- Time arithmetic:
  - sec_ones counts 0-9 and carries into sec_tens.
  - sec_tens counts 0-5 and carries into min_ones.
  - min_ones counts 0-9 and carries into min_tens.
  - min_tens counts 0-5; a carry out of it asserts `wrap` and leaves all digits at 0.
  - Digits never hold non-BCD values.
- A `tc` sampled in the same cycle as a RUN/LAP→PAUSE transition is counted. A `tc` seen in IDLE or PAUSE (which a correct prescaler cannot produce) is ignored.
- `disp` = `lap_reg` in LAP, live time otherwise.

## Timing
- Reset values: state IDLE, all digits 0, `lap_reg`=0, `cnt_enable`=0, `cnt_load`=0, `running`=0, `paused`=0, `wrap`=0, `disp`=16'h0000. `cnt_din`=`PRESET` at all times.
- State, time and `lap_reg` are registered. `cnt_enable`, `cnt_load` and `wrap` are registered outputs. `running`, `paused` and `disp` decode combinationally from registers.
- A button pulse sampled at edge N changes the state at edge N.
- `cnt_enable` and `cnt_load` follow one edge later, at N+1. Consequently the prescaler advances its first count at edge N+2 after `start_stop`.
- `tc` sampled at edge N updates the time, and `disp` reflects it immediately after edge N.
- `wrap` is high for exactly the cycle after the 59:59→00:00 edge.
- `reset` mid-operation forces all reset values asynchronously. The clock is not required.

## Structure
- Shared package `stopwatch_pkg` holds the state encoding localparams (IDLE/RUN/LAP/PAUSE, 2 bits) and the digit limits (9, 5).
- One sub-module, `bcd_digit`, with parameter MAX and ports clk, reset, inc, clr, q[3:0], carry. It is instantiated four times, chained by carry.
- The FSM, lap register and output registers live in `stopwatch_ctrl`. The bench drives `tc` directly, with no prescaler instance.

## Test plan
- Reset, then `start_stop` → `cnt_load`=1 and `cnt_enable`=1 one cycle later; 5 `tc` pulses → `disp`=16'h0005.
- From 00:09, one `tc` → 16'h0010. From 09:59, one `tc` → 16'h1000. From 59:59, one `tc` → 16'h0000 and `wrap` high for one cycle.
- RUN at 00:12, `lap` → `disp` stays 16'h0012 across 3 `tc`. A second `lap` → 16'h0015.
- RUN at 00:07, `start_stop` → `paused`=1 and `cnt_enable`=0; `tc` ignored. `start_stop` again → RUN with no `cnt_load` pulse.
- PAUSE at 00:30, `clear` and `start_stop` in the same cycle → IDLE, `disp`=0, one `cnt_load` pulse. `clear` during RUN → no effect.
- Assert `reset` asynchronously mid-RUN at 03:41 → all outputs reach reset values before the next `clk` edge.
